// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO: captures {parity, byte} on each rising edge of the
// receiver's end-of-reception strobe and serves them first-word-fall-through.
module rx_byte_fifo #(
  parameter int AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           din_i,
  input  logic                 pcheck_i,
  input  logic                 eor_i,
  input  logic                 rd_i,
  input  logic                 clr_ovf_i,
  output logic [7:0]           dout_o,
  output logic                 pflag_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [AddrWidth:0]   count_o,
  output logic                 ovf_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth:0] FullCount = (AddrWidth + 1)'(Depth);

  logic [8:0]           mem [Depth];
  logic [AddrWidth-1:0] wr_ptr_q;
  logic [AddrWidth-1:0] rd_ptr_q;
  logic [AddrWidth:0]   count_q;
  logic                 eor_q;
  logic                 ovf_q;

  logic wr_req;
  logic wr_acc;
  logic rd_acc;

  // Pop handshake: the head is valid whenever empty_o is low; rd_i high in a
  // cycle with the head valid consumes it at the clock edge. rd_i while empty
  // has no effect.
  assign wr_req = eor_i & ~eor_q;
  assign wr_acc = wr_req & (~full_o | rd_i);
  assign rd_acc = rd_i & ~empty_o;

  // eor_q follows eor_i even in reset so a level held across reset release
  // is not mistaken for a new reception.
  always_ff @(posedge clk_i) begin
    eor_q <= eor_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AddrWidth'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + AddrWidth'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + (AddrWidth + 1)'(1);
        2'b01:   count_q <= count_q - (AddrWidth + 1)'(1);
        default: count_q <= count_q;
      endcase
      // A fresh overflow wins over a clear in the same cycle.
      if (wr_req && full_o && !rd_i) ovf_q <= 1'b1;
      else if (clr_ovf_i)            ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && wr_acc) mem[wr_ptr_q] <= {pcheck_i, din_i};
  end

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == FullCount);
    count_o = count_q;
    ovf_o   = ovf_q;
    dout_o  = 8'h00;
    pflag_o = 1'b0;
    if (!empty_o) begin
      dout_o  = mem[rd_ptr_q][7:0];
      pflag_o = mem[rd_ptr_q][8];
    end
  end

endmodule
